// File: rtl/lvds_rx_deframer_pkg.sv
// Shared definitions for the LVDS link: FSM state encoding, default framing
// patterns and the beat-count helper used by both the RX deframer and TX framer.
package lvds_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SYNC   = 3'd3,
    ST_DATA   = 3'd4
  } link_state_e;

  localparam logic [7:0] TRAIN_PAT_DEF = 8'h35;
  localparam logic [7:0] SYNC_PAT_DEF  = 8'h77;

  function automatic int beats_per_word(input int word_w, input int ser_w);
    return word_w / ser_w;
  endfunction

endpackage

// File: rtl/lvds_rx_deframer_if.sv
// Dequeue handshake between the deframer output buffer and its consumer.
interface lvds_rx_deframer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] deq_rx;
  logic              EN_deq_rx;
  logic              RDY_deq_rx;

  modport master (output deq_rx, output EN_deq_rx, input RDY_deq_rx);
  modport slave  (input deq_rx, input EN_deq_rx, output RDY_deq_rx);
endinterface

// File: rtl/lvds_rx_deframer_fifo.sv
// Generic first-word-fall-through FIFO with synchronous flush; head reads as 0 when empty.
module lvds_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             wr_ok_s, rd_ok_s;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rd_ok_s = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_ok_s = wr_en && (!full || rd_ok_s);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_ok_s) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/lvds_rx_deframer.sv
// LVDS receive deframer: bitslip training, sync-word hunt, MSB-beat-first word
// assembly with idle filtering, and a buffered EN/RDY dequeue with drop accounting.
module lvds_rx_deframer
  import lvds_link_pkg::*;
#(
  parameter int              SER_W        = 8,
  parameter int              WORD_W       = 32,
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [SER_W-1:0] TRAIN_PAT   = TRAIN_PAT_DEF,
  parameter logic [SER_W-1:0] SYNC_PAT    = SYNC_PAT_DEF,
  parameter int              SLIP_WAIT    = 3,
  parameter int              SETTLE_CYC   = 6,
  parameter int              VALID_FILTER = 1
) (
  input  logic               rx_outclock,
  input  logic               reset_n,
  input  logic               rx_locked,
  input  logic [SER_W-1:0]   rx_out,
  output logic               rx_data_align,
  output logic               align_done,
  output logic [7:0]         drop_count,
  output logic [2:0]         state_dbg,
  lvds_rx_deframer_if.master deq
);
  localparam int               BEATS     = beats_per_word(WORD_W, SER_W);
  localparam int               BEAT_W    = $clog2(BEATS);
  localparam int               WAIT_W    = $clog2(SLIP_WAIT + 2);
  localparam int               SET_W     = $clog2(SETTLE_CYC + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  link_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              align_q, align_d;
  logic              done_q, done_d;
  logic [7:0]        drop_q, drop_d;
  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_n_s, push_s, drop_s, en_s, full_s, empty_s;
  logic [WORD_W-1:0] word_asm_s, head_s;

  // Reset asserts immediately but is released on a clock edge.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_s    = rst_sync_q[1];

  // Release synchroniser for the external reset.
  always_ff @(posedge rx_outclock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  // Beats shift in from the bottom, so beat 0 ends up in the top slice.
  assign word_asm_s = {word_q[WORD_W-SER_W-1:0], rx_out};
  assign push_s     = rx_locked && (state_q == ST_DATA) && (beat_q == LAST_BEAT) &&
                      ((VALID_FILTER == 0) || word_asm_s[WORD_W-1]);
  assign en_s       = !empty_s && deq.RDY_deq_rx;
  assign drop_s     = push_s && full_s && !en_s;

  // Link FSM next-state and counter updates.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    beat_d   = beat_q;
    word_d   = word_q;
    align_d  = 1'b0;
    done_d   = done_q;
    if (!rx_locked) begin
      state_d  = ST_IDLE;
      wait_d   = '0;
      settle_d = '0;
      beat_d   = '0;
      word_d   = '0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: begin
          if (wait_q != '0) begin
            wait_d = wait_q - WAIT_W'(1);
          end else if (rx_out == TRAIN_PAT) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
          end else begin
            // One count covers the pulse cycle itself, the rest are quiet cycles.
            align_d = 1'b1;
            wait_d  = WAIT_W'(SLIP_WAIT + 1);
          end
        end
        ST_SETTLE: begin
          if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
            state_d = ST_SYNC;
            done_d  = 1'b1;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        ST_SYNC: begin
          if (rx_out == SYNC_PAT) begin
            state_d = ST_DATA;
            beat_d  = '0;
            word_d  = '0;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_DATA: begin
          word_d = word_asm_s;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Saturating count of words lost to a full buffer; survives loss of lock.
  always_comb begin
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge rx_outclock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      settle_q <= '0;
      beat_q   <= '0;
      word_q   <= '0;
      align_q  <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      beat_q   <= beat_d;
      word_q   <= word_d;
      align_q  <= align_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  lvds_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (rx_outclock),
    .rst_n   (rst_n_s),
    .flush   (!rx_locked),
    .wr_en   (push_s),
    .wr_data (word_asm_s),
    .rd_en   (en_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign deq.deq_rx    = head_s;
  assign deq.EN_deq_rx = en_s;
  assign rx_data_align = align_q;
  assign align_done    = done_q;
  assign drop_count    = drop_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Directed bench for lvds_rx_deframer: a bitslip-reversing SERDES model for
// training, then hand-built words covering latency, filtering, back-pressure and lock loss.
module tb_lvds_rx_deframer;
  import lvds_link_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, rx_locked, rx_data_align, align_done, rdy, use_model;
  logic [7:0] din, rx_out, drop_count;
  logic [2:0] state_dbg;
  int         rot;
  int         n_total = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  lvds_rx_deframer_if #(.WORD_W(32)) deq_if ();
  assign deq_if.RDY_deq_rx = rdy;

  function automatic logic [7:0] ror8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  // SERDES model: each observed bitslip undoes one bit of the initial rotation.
  assign rx_out = use_model ? ror8(8'h35, rot) : din;

  lvds_rx_deframer dut (
    .rx_outclock   (clk),
    .reset_n       (reset_n),
    .rx_locked     (rx_locked),
    .rx_out        (rx_out),
    .rx_data_align (rx_data_align),
    .align_done    (align_done),
    .drop_count    (drop_count),
    .state_dbg     (state_dbg),
    .deq           (deq_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] b);
    din = b;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_beat(w[31:24]);
    send_beat(w[23:16]);
    send_beat(w[15:8]);
    send_beat(w[7:0]);
  endtask

  task automatic train(input int start_rot);
    int  pulses;
    int  settle_seen;
    int  last_pulse;
    bit  done;
    use_model   = 1'b1;
    rot         = start_rot;
    pulses      = 0;
    settle_seen = 0;
    last_pulse  = -10;
    done        = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (rx_data_align) begin
        if (pulses > 0) check_eq("slip_gap", 32'((cyc - last_pulse - 1) >= 3), 32'd1);
        pulses++;
        last_pulse = cyc;
        if (rot > 0) rot--;
      end
      if (state_dbg == 3'd2) settle_seen++;
      if (align_done) done = 1'b1;
    end
    check_eq("train_done", 32'(done), 32'd1);
    check_eq("slip_pulses", 32'(pulses), 32'(start_rot));
    check_eq("settle_cycles", 32'(settle_seen), 32'd6);
    check_eq("state_sync", 32'(state_dbg), 32'd3);
    use_model = 1'b0;
    din       = 8'h00;
  endtask

  // Raise RDY and expect n consecutive words base, base+1, ... while an idle word streams in.
  task automatic drain(input logic [31:0] base, input int n);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i < n) begin
        check_eq("drain_data", deq_if.deq_rx, base + 32'(i));
        check_eq("drain_en", 32'(deq_if.EN_deq_rx), 32'd1);
      end
      send_beat(8'h00);
    end
    #1;
    check_eq("drain_empty", 32'(deq_if.EN_deq_rx), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_locked = 1'b1;
    rdy       = 1'b1;
    use_model = 1'b1;
    rot       = 3;
    din       = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_align_done", 32'(align_done), 32'd0);
    check_eq("rst_bitslip", 32'(rx_data_align), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_eq("rst_deq", deq_if.deq_rx, 32'd0);
    check_eq("rst_en", 32'(deq_if.EN_deq_rx), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;

    // Training from a 3-bit rotation, then sync and a first word.
    train(3);
    send_beat(8'h77);
    send_beat(8'hDE);
    send_beat(8'hAD);
    send_beat(8'hBE);
    check_eq("lat_before", 32'(deq_if.EN_deq_rx), 32'd0);
    send_beat(8'hEF);
    check_eq("lat_data", deq_if.deq_rx, 32'hDEADBEEF);
    check_eq("lat_en", 32'(deq_if.EN_deq_rx), 32'd1);
    send_word(32'h0);
    check_eq("pop_empty", 32'(deq_if.EN_deq_rx), 32'd0);

    // Idle filter: MSB-clear word vanishes without counting as a drop.
    send_word(32'h12345678);
    check_eq("filter_gone", 32'(deq_if.EN_deq_rx), 32'd0);
    send_word(32'h80000001);
    check_eq("filter_keep", deq_if.deq_rx, 32'h80000001);
    check_eq("filter_en", 32'(deq_if.EN_deq_rx), 32'd1);
    check_eq("filter_drop", 32'(drop_count), 32'd0);
    send_word(32'h0);
    check_eq("filter_empty", 32'(deq_if.EN_deq_rx), 32'd0);

    // Back-pressure: six words into four slots.
    rdy = 1'b0;
    for (int k = 1; k <= 6; k++) send_word(32'hA0000000 + 32'(k));
    check_eq("full_drop", 32'(drop_count), 32'd2);
    check_eq("full_head", deq_if.deq_rx, 32'hA0000001);
    check_eq("full_en_low", 32'(deq_if.EN_deq_rx), 32'd0);
    drain(32'hA0000001, 4);

    // Full buffer with a pop in the same cycle as the push.
    rdy = 1'b0;
    for (int k = 1; k <= 4; k++) send_word(32'hB0000000 + 32'(k));
    send_beat(8'hB0);
    send_beat(8'h00);
    send_beat(8'h00);
    rdy = 1'b1;
    #1;
    check_eq("pp_head", deq_if.deq_rx, 32'hB0000001);
    check_eq("pp_en", 32'(deq_if.EN_deq_rx), 32'd1);
    send_beat(8'h05);
    rdy = 1'b0;
    #1;
    check_eq("pp_drop", 32'(drop_count), 32'd2);
    check_eq("pp_next", deq_if.deq_rx, 32'hB0000002);
    drain(32'hB0000002, 4);

    // Lock loss at beat 2 with a word waiting in the buffer.
    rdy = 1'b0;
    send_word(32'hC0000001);
    send_beat(8'hC0);
    send_beat(8'h00);
    rx_locked = 1'b0;
    din       = 8'hAA;
    @(negedge clk);
    check_eq("lol_align_done", 32'(align_done), 32'd0);
    check_eq("lol_state", 32'(state_dbg), 32'd0);
    rdy = 1'b1;
    #1;
    check_eq("lol_en", 32'(deq_if.EN_deq_rx), 32'd0);
    check_eq("lol_deq", deq_if.deq_rx, 32'd0);
    check_eq("lol_drop_kept", 32'(drop_count), 32'd2);
    rx_locked = 1'b1;
    train(2);
    send_beat(8'h77);
    send_word(32'hD0000001);
    check_eq("relock_data", deq_if.deq_rx, 32'hD0000001);
    check_eq("relock_en", 32'(deq_if.EN_deq_rx), 32'd1);
    send_word(32'h0);
    check_eq("relock_empty", 32'(deq_if.EN_deq_rx), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
